// File: rtl/instr_reg_ctrl_pkg.sv
// instr_register_pkg: shared types and constants for the instruction register controller
package instr_register_pkg;
  localparam int IR_DEPTH = 32;
  localparam int NUM_REQ = 2;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [$clog2(IR_DEPTH)-1:0] address_t;
  typedef logic [$clog2(IR_DEPTH):0] count_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
  typedef enum logic {IDLE, READ} state_t;
endpackage

// File: rtl/instr_reg_ctrl_if.sv
// instr_reg_ctrl_if: request, write and readback signals; master drives requests/commands, slave is the controller
interface instr_reg_ctrl_if;
  import instr_register_pkg::*;
  logic clear;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  opcode_t req0_opcode;
  opcode_t req1_opcode;
  operand_t req0_operand_a;
  operand_t req0_operand_b;
  operand_t req1_operand_a;
  operand_t req1_operand_b;
  logic load_en;
  opcode_t opcode;
  operand_t operand_a;
  operand_t operand_b;
  address_t write_pointer;
  logic rd_start;
  address_t read_pointer;
  logic rd_valid;
  logic rd_last;
  count_t entry_count;
  logic full;
  modport master (
    output clear, req_valid, req0_opcode, req1_opcode, req0_operand_a, req0_operand_b,
           req1_operand_a, req1_operand_b, rd_start,
    input  req_ready, load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
           rd_valid, rd_last, entry_count, full
  );
  modport slave (
    input  clear, req_valid, req0_opcode, req1_opcode, req0_operand_a, req0_operand_b,
           req1_operand_a, req1_operand_b, rd_start,
    output req_ready, load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
           rd_valid, rd_last, entry_count, full
  );
endinterface

// File: rtl/instr_reg_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter (clk, reset, clear, req, enable -> grant), requester 0 favoured after reset/clear
module rr_arbiter2
  import instr_register_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic [NUM_REQ-1:0] req,
  input  logic enable,
  output logic [NUM_REQ-1:0] grant
);
  logic last;
  assign grant[0] = enable & req[0] & (~req[1] | last);
  assign grant[1] = enable & req[1] & (~req[0] | ~last);
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= 1'b1;
    else if (clear) last <= 1'b1;
    else if (|grant) last <= grant[1];
endmodule

// File: rtl/instr_reg_ctrl.sv
// instr_reg_ctrl: arbitrates two writers into a 32-entry instruction register and sweeps it back (clk, reset, bus slave)
module instr_reg_ctrl
  import instr_register_pkg::*;
(
  input  logic clk,
  input  logic reset,
  instr_reg_ctrl_if.slave bus
);
  state_t state;
  address_t wr_idx;
  logic [NUM_REQ-1:0] grant;
  logic enable;
  logic accept;
  instruction_t sel;
  assign bus.full = bus.entry_count == count_t'(IR_DEPTH);
  // Gating on reset keeps req_ready low while reset is held.
  assign enable = ~reset & (state == IDLE) & ~bus.full & ~bus.clear & ~bus.rd_start;
  rr_arbiter2 u_arb (
    .clk(clk),
    .reset(reset),
    .clear(bus.clear),
    .req(bus.req_valid),
    .enable(enable),
    .grant(grant)
  );
  assign bus.req_ready = grant;
  assign accept = |grant;
  assign sel = grant[1] ? '{bus.req1_opcode, bus.req1_operand_a, bus.req1_operand_b}
                        : '{bus.req0_opcode, bus.req0_operand_a, bus.req0_operand_b};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_idx <= '0;
      bus.load_en <= 1'b0;
      bus.opcode <= ZERO;
      bus.operand_a <= '0;
      bus.operand_b <= '0;
      bus.write_pointer <= '0;
      bus.entry_count <= '0;
      bus.read_pointer <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_last <= 1'b0;
    end else begin
      bus.load_en <= accept;
      if (accept) begin
        bus.opcode <= sel.opc;
        bus.operand_a <= sel.op_a;
        bus.operand_b <= sel.op_b;
        bus.write_pointer <= wr_idx;
      end
      if (bus.clear) begin
        state <= IDLE;
        wr_idx <= '0;
        bus.entry_count <= '0;
        bus.read_pointer <= '0;
        bus.rd_valid <= 1'b0;
        bus.rd_last <= 1'b0;
      end else begin
        if (accept) begin
          wr_idx <= wr_idx + 1'b1;
          bus.entry_count <= bus.entry_count + 1'b1;
        end
        if (state == IDLE) begin
          if (bus.rd_start && bus.entry_count != '0) begin
            state <= READ;
            bus.rd_valid <= 1'b1;
            bus.rd_last <= bus.entry_count == count_t'(1);
            bus.read_pointer <= '0;
          end
        end else if (bus.rd_last) begin
          state <= IDLE;
          bus.rd_valid <= 1'b0;
          bus.rd_last <= 1'b0;
          bus.read_pointer <= '0;
        end else begin
          bus.read_pointer <= bus.read_pointer + 1'b1;
          // The entry after the next one would be past the end: next step is the last.
          bus.rd_last <= count_t'(bus.read_pointer) + count_t'(2) == bus.entry_count;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_reg_ctrl.sv
// tb_instr_reg_ctrl: directed vector table plus hand sequences for instr_reg_ctrl
module tb_instr_reg_ctrl;
  import instr_register_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  instr_reg_ctrl_if bus();
  instr_reg_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic clr, rs;
    logic [1:0] rv, rr;
    logic le;
    int wp;
    opcode_t op;
    int a, b, cnt;
    logic rdv, rdl;
    int rp;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(input logic clr, rs, input logic [1:0] rv, rr, input logic le,
                             input int wp, input opcode_t op, input int a, b, cnt,
                             input logic rdv, rdl, input int rp);
    vec_t r;
    r.clr = clr; r.rs = rs; r.rv = rv; r.rr = rr; r.le = le; r.wp = wp; r.op = op;
    r.a = a; r.b = b; r.cnt = cnt; r.rdv = rdv; r.rdl = rdl; r.rp = rp;
    return r;
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_out(input string tag, input logic [1:0] rr, input logic le, input int wp,
                         input opcode_t op, input int a, b, cnt, input logic rdv, rdl, input int rp);
    chk({tag, ".req_ready"}, longint'(bus.req_ready), longint'(rr));
    chk({tag, ".load_en"}, longint'(bus.load_en), longint'(le));
    chk({tag, ".write_pointer"}, longint'(bus.write_pointer), longint'(wp));
    chk({tag, ".opcode"}, longint'(bus.opcode), longint'(op));
    chk({tag, ".operand_a"}, longint'(bus.operand_a), longint'(a));
    chk({tag, ".operand_b"}, longint'(bus.operand_b), longint'(b));
    chk({tag, ".entry_count"}, longint'(bus.entry_count), longint'(cnt));
    chk({tag, ".full"}, longint'(bus.full), longint'(cnt == 32));
    chk({tag, ".rd_valid"}, longint'(bus.rd_valid), longint'(rdv));
    chk({tag, ".rd_last"}, longint'(bus.rd_last), longint'(rdl));
    chk({tag, ".read_pointer"}, longint'(bus.read_pointer), longint'(rp));
  endtask
  task automatic drive(input logic clr, rs, input logic [1:0] rv);
    bus.clear = clr;
    bus.rd_start = rs;
    bus.req_valid = rv;
  endtask
  task automatic payload(input int i);
    bus.req0_opcode = ADD;
    bus.req0_operand_a = i;
    bus.req0_operand_b = 3;
    bus.req1_opcode = MULT;
    bus.req1_operand_a = -i;
    bus.req1_operand_b = i + 100;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    tbl.push_back(v(0,0,2'b11, 2'b01,0,0,ZERO,0,0,0, 0,0,0));
    tbl.push_back(v(0,0,2'b11, 2'b10,1,0,ADD,0,3,1, 0,0,0));
    tbl.push_back(v(0,0,2'b11, 2'b01,1,1,MULT,-1,101,2, 0,0,0));
    tbl.push_back(v(0,1,2'b10, 2'b00,1,2,ADD,2,3,3, 0,0,0));
    tbl.push_back(v(0,0,2'b10, 2'b00,0,2,ADD,2,3,3, 1,0,0));
    tbl.push_back(v(0,0,2'b10, 2'b00,0,2,ADD,2,3,3, 1,0,1));
    tbl.push_back(v(0,0,2'b10, 2'b00,0,2,ADD,2,3,3, 1,1,2));
    tbl.push_back(v(0,0,2'b10, 2'b10,0,2,ADD,2,3,3, 0,0,0));
    tbl.push_back(v(0,0,2'b01, 2'b01,1,3,MULT,-7,107,4, 0,0,0));
    tbl.push_back(v(0,1,2'b00, 2'b00,1,4,ADD,8,3,5, 0,0,0));
    tbl.push_back(v(0,1,2'b11, 2'b00,0,4,ADD,8,3,5, 1,0,0));
    tbl.push_back(v(1,0,2'b00, 2'b00,0,4,ADD,8,3,5, 1,0,1));
    tbl.push_back(v(0,0,2'b00, 2'b00,0,4,ADD,8,3,0, 0,0,0));
    tbl.push_back(v(0,0,2'b11, 2'b01,0,4,ADD,8,3,0, 0,0,0));
    tbl.push_back(v(1,0,2'b00, 2'b00,1,0,ADD,13,3,1, 0,0,0));
    tbl.push_back(v(0,0,2'b01, 2'b01,0,0,ADD,13,3,0, 0,0,0));
    tbl.push_back(v(0,0,2'b00, 2'b00,1,0,ADD,15,3,1, 0,0,0));
    tbl.push_back(v(1,1,2'b00, 2'b00,0,0,ADD,15,3,1, 0,0,0));
    tbl.push_back(v(0,0,2'b00, 2'b00,0,0,ADD,15,3,0, 0,0,0));
    tbl.push_back(v(0,1,2'b00, 2'b00,0,0,ADD,15,3,0, 0,0,0));
    tbl.push_back(v(0,0,2'b10, 2'b10,0,0,ADD,15,3,0, 0,0,0));
    tbl.push_back(v(0,0,2'b00, 2'b00,1,0,MULT,-20,120,1, 0,0,0));
    tbl.push_back(v(0,1,2'b00, 2'b00,0,0,MULT,-20,120,1, 0,0,0));
    tbl.push_back(v(0,0,2'b00, 2'b00,0,0,MULT,-20,120,1, 1,1,0));
    tbl.push_back(v(0,0,2'b00, 2'b00,0,0,MULT,-20,120,1, 0,0,0));
    payload(0);
    drive(1, 1, 2'b11);
    repeat (2) @(negedge clk);
    #2 chk_out("reset_hold", 2'b00,0,0,ZERO,0,0,0, 0,0,0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 2'b01);
    bus.req0_operand_a = 5;
    #2 chk("single_req0.req_ready", longint'(bus.req_ready), 1);
    @(negedge clk);
    drive(0, 0, 2'b00);
    #2 chk_out("single_req0", 2'b00,1,0,ADD,5,3,1, 0,0,0);
    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      payload(i);
      drive(tbl[i].clr, tbl[i].rs, tbl[i].rv);
      #2 chk_out($sformatf("vec%0d", i), tbl[i].rr, tbl[i].le, tbl[i].wp, tbl[i].op,
                 tbl[i].a, tbl[i].b, tbl[i].cnt, tbl[i].rdv, tbl[i].rdl, tbl[i].rp);
    end
    do_reset();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      payload(k);
      drive(0, 0, 2'b01);
    end
    @(negedge clk);
    drive(0, 0, 2'b11);
    #2 chk_out("full_first", 2'b00,1,31,ADD,31,3,32, 0,0,0);
    @(negedge clk);
    #2 chk_out("full_hold", 2'b00,0,31,ADD,31,3,32, 0,0,0);
    @(negedge clk);
    drive(0, 1, 2'b00);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      drive(0, 0, 2'b00);
      #2 chk_out($sformatf("sweep%0d", k), 2'b00,0,31,ADD,31,3,32, 1,k == 31,k);
    end
    @(negedge clk);
    #2 chk_out("sweep_done", 2'b00,0,31,ADD,31,3,32, 0,0,0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      payload(k + 40);
      drive(0, 0, 2'b01);
    end
    @(negedge clk);
    drive(0, 1, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 0, 2'b11);
      #2 chk("abort.read_pointer", longint'(bus.read_pointer), longint'(k));
    end
    reset = 1'b1;
    #1 chk_out("abort_read", 2'b00,0,0,ZERO,0,0,0, 0,0,0);
    @(negedge clk);
    reset = 1'b0;
    #2 chk("abort.first_grant", longint'(bus.req_ready), 1);
    @(negedge clk);
    drive(0, 0, 2'b00);
    #2 chk("abort.load_en", longint'(bus.load_en), 1);
    reset = 1'b1;
    #1 chk("midwrite.load_en_reset", longint'(bus.load_en), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2 chk_out("midwrite_after", 2'b00,0,0,ZERO,0,0,0, 0,0,0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_reg_ctrl.md
INSTR_REG_CTRL -- requirements
Module: instr_reg_ctrl

Interface
REQ-001 Parameters: none; depth SHALL come from package constant IR_DEPTH = 32 (address_t 5 bits).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high; ports clk and reset.
REQ-003 Ports, in order (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- clear  in  1  sync flush of pointers and count
- req_valid  in  2  per-requester write request
- req_ready  out  2  per-requester accept, one-hot or zero
- req0_opcode, req1_opcode  in  opcode_t (4)  requested opcode
- req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b  in  operand_t (32, signed)  requested operands
- load_en  out  1  write strobe to instr_register
- opcode  out  opcode_t  write payload
- operand_a, operand_b  out  operand_t  write payload
- write_pointer  out  address_t  write slot
- rd_start  in  1  start readback sweep
- read_pointer  out  address_t  read slot
- rd_valid  out  1  instruction_word valid this cycle
- rd_last  out  1  final sweep entry
- entry_count  out  6  entries stored, 0..32
- full  out  1  entry_count == 32

Function
REQ-004 FSM states SHALL be IDLE and READ only; reset state is IDLE.
REQ-005 Transaction SHALL be accepted in cycle N iff req_valid[i] & req_ready[i].
REQ-006 req_ready SHALL be 0 when: state is READ, full=1, clear=1, or rd_start=1 in IDLE.
REQ-007 Arbitration SHALL be round-robin: one valid requester wins alone; two valid requesters go to the one not granted last; after reset requester 0 has priority.
REQ-008 Accept in cycle N SHALL drive load_en=1 in cycle N+1 with the registered opcode, operands, and write_pointer = write index; otherwise load_en=0, payload held.
REQ-009 Write index and entry_count SHALL increment by 1 per accept; write index wraps 31->0 only when count reaches 32, and no further accepts occur.
REQ-010 rd_start in IDLE with entry_count>0 at cycle N SHALL enter READ at N+1; rd_start with count 0, or in READ, SHALL be ignored.
REQ-011 In READ, read_pointer SHALL step 0,1,...,entry_count-1 one per cycle with rd_valid=1; rd_last=1 on the final entry; then IDLE.
REQ-012 In IDLE, rd_valid and rd_last SHALL be 0 and read_pointer 0.
REQ-013 A load_en from an accept at N-1 SHALL still issue in cycle N when rd_start is sampled at N, so the sweep sees all entries.
REQ-014 clear SHALL, in any state: reset write index, entry_count, and read_pointer to 0; return to IDLE; restore requester-0 priority; force rd_valid=0 next cycle. A pending load_en still issues.
REQ-015 entry_count SHALL be unchanged by reads; full SHALL be combinational from entry_count.

Reset
REQ-016 While reset=1, outputs SHALL be: load_en, rd_valid, rd_last, full, and req_ready 0; opcode ZERO; operands, write_pointer, read_pointer, and entry_count 0; state IDLE. Reset overrides clear and rd_start.
REQ-017 Reset asserted mid-READ or mid-write SHALL abort immediately with no load_en after deassertion.

Structure
REQ-018 opcode_t, operand_t, address_t, instruction_t, IR_DEPTH and NUM_REQ=2 SHALL live in instr_register_pkg.
REQ-019 Arbitration SHALL be a sub-module rr_arbiter2 (req[1:0], enable -> grant[1:0], updates last-grant on accept).

Verification
REQ-020 Only req0 valid, ADD a=5 b=3 -> req_ready=01; next cycle load_en=1, write_pointer=0, opcode ADD, a=5, b=3; entry_count=1.
REQ-021 req_valid=11 for 3 cycles after reset -> grants 01,10,01; write_pointer 0,1,2; entry_count=3.
REQ-022 32 accepts, then req_valid=11 -> full=1, req_ready=00, entry_count=32, no load_en.
REQ-023 count=3, rd_start with req1 valid same cycle -> req_ready=00 that cycle; next 3 cycles read_pointer 0,1,2 with rd_valid=1, rd_last on 2; then IDLE, req1 accepted, write_pointer=3.
REQ-024 clear during READ at read_pointer=1 -> next cycle rd_valid=0, entry_count=0; next accept writes slot 0.
REQ-025 reset pulse mid-READ at read_pointer=2 -> all outputs at reset values, state IDLE; first accept afterwards goes to requester 0.
